// File: rtl/noc_traffic_pkg.sv
// Shared flit layout, FSM encodings and flit builders for the NoC traffic node.
// Optional build macro NOC_TRAFFIC_BACKPRESSURE_EN is consumed by noc_traffic_node.
`ifndef Noc_Data_Width
`define Noc_Data_Width 64
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif
`ifndef Axi_LEN_Bit
`define Axi_LEN_Bit 8
`endif
`ifndef Noc_Head_H
`define Noc_Head_H 4'hA
`endif
`ifndef Noc_Head_E
`define Noc_Head_E 4'h5
`endif
`ifndef Noc_Tail_H
`define Noc_Tail_H 4'hC
`endif
`ifndef Noc_Tail_E
`define Noc_Tail_E 4'h3
`endif

package noc_traffic_pkg;

  localparam int DATA_W = `Noc_Data_Width;
  localparam int ID_X_W = `Noc_ID_X_Width;
  localparam int ID_Y_W = `Noc_ID_Y_Width;
  localparam int LEN_W  = `Axi_LEN_Bit;
  localparam int MARK_W = 4;

  localparam logic [MARK_W-1:0] MARK_HEAD_H = `Noc_Head_H;
  localparam logic [MARK_W-1:0] MARK_HEAD_E = `Noc_Head_E;
  localparam logic [MARK_W-1:0] MARK_TAIL_H = `Noc_Tail_H;
  localparam logic [MARK_W-1:0] MARK_TAIL_E = `Noc_Tail_E;

  // Flit layout, MSB first: H marker | src X,Y | dest X,Y | type(2) | order(8) | len | E marker | pad
  localparam int Noc_Point_H      = DATA_W - 1;
  localparam int Noc_Source_Point = Noc_Point_H - MARK_W;
  localparam int Noc_Dest_Point   = Noc_Source_Point - ID_X_W - ID_Y_W;
  localparam int Noc_Type_Point   = Noc_Dest_Point - ID_X_W - ID_Y_W;
  localparam int Noc_Order_Point  = Noc_Type_Point - 2;
  localparam int Axi_Len_Point    = Noc_Order_Point - 8;
  localparam int Noc_Point_E      = Axi_Len_Point - LEN_W;
  localparam int PAD_W            = Noc_Point_E - MARK_W + 1;

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0,
    TX_HEAD = 3'd1,
    TX_BODY = 3'd2,
    TX_TAIL = 3'd3,
    TX_GAP  = 3'd4
  } tx_state_e;

  typedef enum logic {
    RX_WAIT_HEAD = 1'b0,
    RX_BODY      = 1'b1
  } rx_state_e;

  function automatic logic [DATA_W-1:0] body_pattern(input logic [7:0] pkt_idx,
                                                     input logic [7:0] idx);
    return {(DATA_W / 16){pkt_idx, idx}};
  endfunction

  function automatic logic [DATA_W-1:0] make_flit(input logic [MARK_W-1:0] mark_h,
                                                  input logic [MARK_W-1:0] mark_e,
                                                  input logic [ID_X_W-1:0] src_x,
                                                  input logic [ID_Y_W-1:0] src_y,
                                                  input logic [ID_X_W-1:0] dst_x,
                                                  input logic [ID_Y_W-1:0] dst_y,
                                                  input logic [7:0]        order,
                                                  input logic [LEN_W-1:0]  len);
    return {mark_h, src_x, src_y, dst_x, dst_y, 2'b00, order, len, mark_e, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/noc_traffic_rx_ctx.sv
// One receive virtual-channel context: framing, source, length and payload checks.
// Emits single-cycle good/err pulses that the top sums into its counters.
module noc_traffic_rx_ctx
  import noc_traffic_pkg::*;
(
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic              flit_acc,
  input  logic [DATA_W-1:0] flit,
  input  logic              is_header,
  input  logic              is_tail,
  output logic              pkt_good,
  output logic              pkt_err
);

  rx_state_e         state, state_nxt;
  logic [ID_X_W-1:0] src_x;
  logic [ID_Y_W-1:0] src_y;
  logic [7:0]        pkt_idx;
  logic [LEN_W-1:0]  len;
  // Extra MSB keeps an overlong packet from wrapping back onto a length match
  logic [LEN_W:0]    body_cnt;
  logic              err_flag;

  logic head_ok, tail_ok, src_ok, len_ok, body_ok, tail_good;

  assign head_ok = (flit[Noc_Point_H -: MARK_W] == MARK_HEAD_H) &&
                   (flit[Noc_Point_E -: MARK_W] == MARK_HEAD_E);
  assign tail_ok = (flit[Noc_Point_H -: MARK_W] == MARK_TAIL_H) &&
                   (flit[Noc_Point_E -: MARK_W] == MARK_TAIL_E);
  assign src_ok  = (flit[Noc_Source_Point -: ID_X_W] == src_x) &&
                   (flit[Noc_Source_Point - ID_X_W -: ID_Y_W] == src_y);
  assign len_ok  = (body_cnt == {1'b0, len});
  assign body_ok = (flit == body_pattern(pkt_idx, body_cnt[7:0]));
  assign tail_good = tail_ok && src_ok && len_ok && !err_flag;

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) state <= RX_WAIT_HEAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flit_acc) begin
      case (state)
        RX_WAIT_HEAD: if (is_header && head_ok) state_nxt = RX_BODY;
        RX_BODY: begin
          if (is_header)    state_nxt = head_ok ? RX_BODY : RX_WAIT_HEAD;
          else if (is_tail) state_nxt = RX_WAIT_HEAD;
        end
        default: state_nxt = RX_WAIT_HEAD;
      endcase
    end
  end

  always_comb begin
    pkt_good = 1'b0;
    pkt_err  = 1'b0;
    if (flit_acc) begin
      case (state)
        RX_WAIT_HEAD: pkt_err = !(is_header && head_ok);
        RX_BODY: begin
          if (is_header) begin
            pkt_err = 1'b1;
          end else if (is_tail) begin
            pkt_good = tail_good;
            pkt_err  = !tail_good;
          end
        end
        default: pkt_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      body_cnt <= '0;
      err_flag <= 1'b0;
    end else if (flit_acc) begin
      if (is_header) begin
        body_cnt <= '0;
        err_flag <= 1'b0;
      end else if (state == RX_BODY && !is_tail) begin
        if (body_cnt != '1) body_cnt <= body_cnt + (LEN_W + 1)'(1);
        if (!body_ok)       err_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge noc_clk) begin
    if (flit_acc && is_header && head_ok) begin
      src_x   <= flit[Noc_Source_Point -: ID_X_W];
      src_y   <= flit[Noc_Source_Point - ID_X_W -: ID_Y_W];
      pkt_idx <= flit[Noc_Order_Point -: 8];
      len     <= flit[Axi_Len_Point -: LEN_W];
    end
  end

endmodule

// File: rtl/noc_traffic_node.sv
// NoC endpoint traffic generator (burst sender) and per-VC packet checker.
// Define NOC_TRAFFIC_BACKPRESSURE_EN to drive receive_ready from a 16-bit LFSR.
module noc_traffic_node
  import noc_traffic_pkg::*;
#(
  parameter logic [ID_X_W-1:0] X_ID      = '0,
  parameter logic [ID_Y_W-1:0] Y_ID      = '0,
  parameter logic [ID_X_W-1:0] DEST_X_ID = '0,
  parameter logic [ID_Y_W-1:0] DEST_Y_ID = '0,
  parameter int                PKT_NUM   = 4,
  parameter int                BODY_LEN  = 1,
  parameter int                VC_NUM    = 2,
  parameter int                GAP_CYC   = 0,
  parameter int                TX_VC     = 0
) (
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic              send_start,
  output logic              send_busy,
  output logic              send_done,
  output logic              sender_valid,
  input  logic              sender_ready,
  output logic [DATA_W-1:0] sender_flit,
  output logic              sender_is_header,
  output logic              sender_is_tail,
  output logic [1:0]        sender_vc,
  input  logic [VC_NUM-1:0] receive_valid,
  output logic [VC_NUM-1:0] receive_ready,
  input  logic [DATA_W-1:0] receive_flit,
  input  logic              receive_is_header,
  input  logic              receive_is_tail,
  output logic [15:0]       rx_pkt_cnt,
  output logic [15:0]       rx_err_cnt
);

  localparam logic [7:0]       LAST_PKT  = 8'(PKT_NUM - 1);
  localparam logic [7:0]       LAST_BODY = 8'(BODY_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_VAL   = LEN_W'(BODY_LEN);
  localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYC - 1);

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [2:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {14'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  tx_state_e  tx_state, tx_state_nxt;
  logic [7:0] pkt_idx, body_idx;
  logic [3:0] gap_cnt;
  logic       tx_xfer, tx_last_tail;

  assign tx_xfer      = sender_valid & sender_ready;
  assign tx_last_tail = tx_xfer && (tx_state == TX_TAIL) && (pkt_idx == LAST_PKT);
  assign sender_vc    = 2'(TX_VC);

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) tx_state <= TX_IDLE;
    else         tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE: if (send_start) tx_state_nxt = TX_HEAD;
      TX_HEAD: if (tx_xfer) tx_state_nxt = TX_BODY;
      TX_BODY: if (tx_xfer && body_idx == LAST_BODY) tx_state_nxt = TX_TAIL;
      TX_TAIL: begin
        if (tx_xfer) begin
          if (pkt_idx == LAST_PKT) tx_state_nxt = TX_IDLE;
          else if (GAP_CYC == 0)   tx_state_nxt = TX_HEAD;
          else                     tx_state_nxt = TX_GAP;
        end
      end
      TX_GAP:  if (gap_cnt == GAP_LAST) tx_state_nxt = TX_HEAD;
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // Flit and markers derive from state alone, so they stay stable under backpressure
  always_comb begin
    sender_valid     = 1'b0;
    sender_is_header = 1'b0;
    sender_is_tail   = 1'b0;
    sender_flit      = '0;
    send_busy        = (tx_state != TX_IDLE);
    case (tx_state)
      TX_HEAD: begin
        sender_valid     = 1'b1;
        sender_is_header = 1'b1;
        sender_flit      = make_flit(MARK_HEAD_H, MARK_HEAD_E, X_ID, Y_ID,
                                     DEST_X_ID, DEST_Y_ID, pkt_idx, LEN_VAL);
      end
      TX_BODY: begin
        sender_valid = 1'b1;
        sender_flit  = body_pattern(pkt_idx, body_idx);
      end
      TX_TAIL: begin
        sender_valid   = 1'b1;
        sender_is_tail = 1'b1;
        sender_flit    = make_flit(MARK_TAIL_H, MARK_TAIL_E, X_ID, Y_ID,
                                   DEST_X_ID, DEST_Y_ID, pkt_idx, LEN_VAL);
      end
      default: sender_valid = 1'b0;
    endcase
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      pkt_idx   <= '0;
      body_idx  <= '0;
      gap_cnt   <= '0;
      send_done <= 1'b0;
    end else begin
      send_done <= tx_last_tail;
      case (tx_state)
        TX_IDLE: begin
          if (send_start) begin
            pkt_idx  <= '0;
            body_idx <= '0;
          end
        end
        TX_BODY: if (tx_xfer) body_idx <= (body_idx == LAST_BODY) ? 8'd0 : body_idx + 8'd1;
        TX_TAIL: begin
          if (tx_xfer) begin
            pkt_idx <= pkt_idx + 8'd1;
            gap_cnt <= '0;
          end
        end
        TX_GAP:  gap_cnt <= gap_cnt + 4'd1;
        default: gap_cnt <= gap_cnt;
      endcase
    end
  end

  // Receive side: ready comes up on the first edge out of reset
  logic rdy_en;

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) rdy_en <= 1'b0;
    else         rdy_en <= 1'b1;
  end

`ifdef NOC_TRAFFIC_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign receive_ready = rdy_en ? ~lfsr[VC_NUM-1:0] : '0;
`else
  assign receive_ready = {VC_NUM{rdy_en}};
`endif

  logic [VC_NUM-1:0] rx_acc, vc_good, vc_err;
  logic              rx_multi;
  logic [2:0]        good_inc, err_inc;

  assign rx_acc   = receive_valid & receive_ready;
  assign rx_multi = (rx_acc & (rx_acc - VC_NUM'(1))) != '0;

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    noc_traffic_rx_ctx u_ctx (
      .noc_clk   (noc_clk),
      .noc_rst   (noc_rst),
      .flit_acc  (rx_acc[v] & ~rx_multi),
      .flit      (receive_flit),
      .is_header (receive_is_header),
      .is_tail   (receive_is_tail),
      .pkt_good  (vc_good[v]),
      .pkt_err   (vc_err[v])
    );
  end

  always_comb begin
    good_inc = '0;
    err_inc  = {2'b00, rx_multi};
    for (int v = 0; v < VC_NUM; v++) begin
      good_inc = good_inc + {2'b00, vc_good[v]};
      err_inc  = err_inc + {2'b00, vc_err[v]};
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      rx_pkt_cnt <= '0;
      rx_err_cnt <= '0;
    end else begin
      rx_pkt_cnt <= sat_add(rx_pkt_cnt, good_inc);
      rx_err_cnt <= sat_add(rx_err_cnt, err_inc);
    end
  end

endmodule

// File: tb/tb_noc_traffic_node.sv
// Directed bench for noc_traffic_node: burst sender, backpressure, loopback and RX checker.
module tb_noc_traffic_node;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_start, a_busy, a_done, a_valid, a_ready, a_hdr, a_tail;
  logic [63:0] a_flit;
  logic [1:0]  a_vc;
  logic [1:0]  a_rvalid, a_rready;
  logic [63:0] a_rflit;
  logic        a_rhdr, a_rtail;
  logic [15:0] a_pkt, a_err;

  logic        b_start, b_busy, b_done, b_valid, b_hdr, b_tail;
  logic [63:0] b_flit;
  logic [1:0]  b_vc;
  logic [1:0]  b_rready;
  logic [15:0] b_pkt, b_err;
  logic        b_sready;
  logic [1:0]  b_rvalid;

  assign b_sready = b_rready[0];
  assign b_rvalid = {1'b0, b_valid};

  noc_traffic_node #(
    .X_ID(4'd1), .Y_ID(4'd2), .DEST_X_ID(4'd3), .DEST_Y_ID(4'd4),
    .PKT_NUM(2), .BODY_LEN(3), .VC_NUM(2), .GAP_CYC(0), .TX_VC(0)
  ) u_a (
    .noc_clk(clk), .noc_rst(rst), .send_start(a_start), .send_busy(a_busy),
    .send_done(a_done), .sender_valid(a_valid), .sender_ready(a_ready),
    .sender_flit(a_flit), .sender_is_header(a_hdr), .sender_is_tail(a_tail),
    .sender_vc(a_vc), .receive_valid(a_rvalid), .receive_ready(a_rready),
    .receive_flit(a_rflit), .receive_is_header(a_rhdr), .receive_is_tail(a_rtail),
    .rx_pkt_cnt(a_pkt), .rx_err_cnt(a_err)
  );

  noc_traffic_node #(
    .X_ID(4'd5), .Y_ID(4'd6), .DEST_X_ID(4'd5), .DEST_Y_ID(4'd6),
    .PKT_NUM(4), .BODY_LEN(2), .VC_NUM(2), .GAP_CYC(1), .TX_VC(0)
  ) u_b (
    .noc_clk(clk), .noc_rst(rst), .send_start(b_start), .send_busy(b_busy),
    .send_done(b_done), .sender_valid(b_valid), .sender_ready(b_sready),
    .sender_flit(b_flit), .sender_is_header(b_hdr), .sender_is_tail(b_tail),
    .sender_vc(b_vc), .receive_valid(b_rvalid), .receive_ready(b_rready),
    .receive_flit(b_flit), .receive_is_header(b_hdr), .receive_is_tail(b_tail),
    .rx_pkt_cnt(b_pkt), .rx_err_cnt(b_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flit layout: H | srcX | srcY | dstX | dstY | type(2) | order(8) | len(8) | E | 22'b0
  function automatic logic [63:0] mk_flit(input logic [3:0] mh, input logic [3:0] me,
                                          input logic [3:0] sx, input logic [3:0] sy,
                                          input logic [3:0] dx, input logic [3:0] dy,
                                          input logic [7:0] ord, input logic [7:0] len);
    return {mh, sx, sy, dx, dy, 2'b00, ord, len, me, 22'h0};
  endfunction

  function automatic logic [63:0] hd(input logic [7:0] p, input logic [7:0] l);
    return mk_flit(4'hA, 4'h5, 4'd7, 4'd7, 4'd1, 4'd2, p, l);
  endfunction

  function automatic logic [63:0] tl(input logic [7:0] p, input logic [7:0] l);
    return mk_flit(4'hC, 4'h3, 4'd7, 4'd7, 4'd1, 4'd2, p, l);
  endfunction

  function automatic logic [63:0] bp(input logic [7:0] p, input logic [7:0] i);
    return {4{p, i}};
  endfunction

  typedef struct {
    logic [1:0]  vld;
    logic        hdr;
    logic        tail;
    logic [63:0] flit;
    logic [15:0] exp_pkt;
    logic [15:0] exp_err;
  } rx_vec_t;

  function automatic rx_vec_t mkv(input logic [1:0] vld, input logic hdr, input logic tail,
                                  input logic [63:0] flit, input int ep, input int ee);
    rx_vec_t r;
    r.vld = vld; r.hdr = hdr; r.tail = tail; r.flit = flit;
    r.exp_pkt = 16'(ep); r.exp_err = 16'(ee);
    return r;
  endfunction

  rx_vec_t     vecs[$];
  logic [63:0] exp_tx[10];
  logic [2:0]  rdy_seq;
  int          hdr_xfers;
  logic        seen;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_ready = 1'b0; a_rvalid = 2'b00; a_rflit = '0; a_rhdr = 1'b0; a_rtail = 1'b0;
    b_start = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_flit", a_flit, 0);
    chk("rst_a_rready", a_rready, 0);
    chk("rst_a_cnts", {a_pkt, a_err}, 0);
    chk("rst_b_rready", b_rready, 0);
    rst = 1'b0;
    step();
    chk("rready_after_rst", a_rready, 2'b11);
    chk("a_vc", a_vc, 0);

    // Burst of 2 packets x (hdr + 3 body + tail), ready held high
    exp_tx[0] = 64'hA123_4000_0D40_0000;
    exp_tx[1] = 64'h0000_0000_0000_0000;
    exp_tx[2] = 64'h0001_0001_0001_0001;
    exp_tx[3] = 64'h0002_0002_0002_0002;
    exp_tx[4] = mk_flit(4'hC, 4'h3, 4'd1, 4'd2, 4'd3, 4'd4, 8'd0, 8'd3);
    exp_tx[5] = 64'hA123_4004_0D40_0000;
    exp_tx[6] = 64'h0100_0100_0100_0100;
    exp_tx[7] = 64'h0101_0101_0101_0101;
    exp_tx[8] = 64'h0102_0102_0102_0102;
    exp_tx[9] = mk_flit(4'hC, 4'h3, 4'd1, 4'd2, 4'd3, 4'd4, 8'd1, 8'd3);
    a_ready = 1'b1;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_valid_%0d", i), a_valid, 1);
      chk($sformatf("tx_flit_%0d", i), a_flit, exp_tx[i]);
      chk($sformatf("tx_marks_%0d", i), {a_hdr, a_tail},
          {(i == 0 || i == 5), (i == 4 || i == 9)});
      chk($sformatf("tx_done_low_%0d", i), a_done, 0);
      step();
    end
    chk("tx_done_pulse", a_done, 1);
    chk("tx_busy_clear", a_busy, 0);
    chk("tx_valid_clear", a_valid, 0);
    step();
    chk("tx_done_one_cycle", a_done, 0);

    // Header under backpressure: ready 1 (idle), 0, 0, 1
    rdy_seq = 3'b100;
    a_ready = 1'b1;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    hdr_xfers = 0;
    for (int k = 0; k < 3; k++) begin
      a_ready = rdy_seq[k];
      chk($sformatf("bp_hdr_flit_%0d", k), a_flit, exp_tx[0]);
      chk($sformatf("bp_hdr_mark_%0d", k), {a_valid, a_hdr}, 2'b11);
      if (a_valid && a_ready && a_hdr) hdr_xfers++;
      step();
    end
    chk("bp_hdr_xfers", hdr_xfers, 1);
    chk("bp_first_body", {a_hdr, a_flit}, {1'b0, exp_tx[1]});
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (a_done) seen = 1'b1;
      else step();
    end
    chk("bp_done_seen", seen, 1);

    // Loopback on unit B: 4 packets, BODY_LEN=2, one gap cycle
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (b_done) seen = 1'b1;
      else step();
    end
    chk("loop_done_seen", seen, 1);
    chk("loop_pkt_cnt", b_pkt, 4);
    chk("loop_err_cnt", b_err, 0);

    // Receive-checker vectors on unit A (cumulative expected counts)
    vecs.push_back(mkv(2'b01, 1, 0, hd(0, 2), 0, 0));
    vecs.push_back(mkv(2'b10, 1, 0, hd(1, 1), 0, 0));
    vecs.push_back(mkv(2'b01, 0, 0, bp(0, 0), 0, 0));
    vecs.push_back(mkv(2'b10, 0, 0, bp(1, 0), 0, 0));
    vecs.push_back(mkv(2'b01, 0, 0, bp(0, 1), 0, 0));
    vecs.push_back(mkv(2'b10, 0, 1, tl(1, 1), 1, 0));
    vecs.push_back(mkv(2'b01, 0, 1, tl(0, 2), 2, 0));
    vecs.push_back(mkv(2'b00, 0, 0, 64'hFFFF_0000_FFFF_0000, 2, 0));
    vecs.push_back(mkv(2'b10, 0, 0, bp(2, 0), 2, 1));
    vecs.push_back(mkv(2'b10, 1, 0, hd(2, 2), 2, 1));
    vecs.push_back(mkv(2'b10, 0, 0, bp(2, 0), 2, 1));
    vecs.push_back(mkv(2'b10, 0, 0, 64'hDEAD_BEEF_0000_0001, 2, 1));
    vecs.push_back(mkv(2'b10, 0, 1, tl(2, 2), 2, 2));
    vecs.push_back(mkv(2'b11, 1, 0, hd(3, 1), 2, 3));
    vecs.push_back(mkv(2'b01, 1, 0, hd(4, 1), 2, 3));
    vecs.push_back(mkv(2'b01, 1, 0, hd(5, 1), 2, 4));
    vecs.push_back(mkv(2'b01, 0, 0, bp(5, 0), 2, 4));
    vecs.push_back(mkv(2'b01, 0, 1, tl(5, 1), 3, 4));
    vecs.push_back(mkv(2'b10, 1, 0, hd(6, 1), 3, 4));
    vecs.push_back(mkv(2'b10, 0, 0, bp(6, 0), 3, 4));
    vecs.push_back(mkv(2'b10, 0, 1, mk_flit(4'hC, 4'h3, 4'd8, 4'd7, 4'd1, 4'd2, 8'd6, 8'd1), 3, 5));
    vecs.push_back(mkv(2'b01, 1, 0, hd(7, 2), 3, 5));
    vecs.push_back(mkv(2'b01, 0, 0, bp(7, 0), 3, 5));
    vecs.push_back(mkv(2'b01, 0, 1, tl(7, 2), 3, 6));
    vecs.push_back(mkv(2'b01, 1, 0, 64'h0, 3, 7));
    for (int i = 0; i < vecs.size(); i++) begin
      a_rvalid = vecs[i].vld;
      a_rhdr   = vecs[i].hdr;
      a_rtail  = vecs[i].tail;
      a_rflit  = vecs[i].flit;
      step();
      chk($sformatf("rx_pkt_%0d", i), a_pkt, vecs[i].exp_pkt);
      chk($sformatf("rx_err_%0d", i), a_err, vecs[i].exp_err);
    end
    a_rvalid = 2'b00; a_rhdr = 1'b0; a_rtail = 1'b0;

    // Reset mid-body, then a fresh burst
    a_ready = 1'b1;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    step();
    step();
    chk("pre_rst_in_body", {a_valid, a_hdr, a_tail}, 3'b100);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", a_valid, 0);
    chk("rst_async_cnts", {a_pkt, a_err}, 0);
    chk("rst_async_rready", a_rready, 0);
    step();
    step();
    chk("rst_held_valid", a_valid, 0);
    rst = 1'b0;
    step();
    chk("rst_release_rready", a_rready, 2'b11);
    chk("rst_release_idle", {a_valid, a_busy}, 0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("restart_hdr_mark", {a_valid, a_hdr}, 2'b11);
    chk("restart_order", a_flit[41:34], 0);
    chk("restart_hdr_flit", a_flit, exp_tx[0]);
    chk("restart_no_err", a_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
